// File: rtl/gat_bram_bridge.sv
// Host-to-core bridge for the GAT accelerator: aligns and counts host BRAM writes,
// checks per-channel load completion, sequences core start/ready, and provides feature readback.
module gat_bram_bridge #(
    parameter int TOP_WIDTH     = 32,
    parameter int NUM_CH        = 3,
    parameter int CH_DATA_WIDTH = 19,
    parameter int CH_ADDR_W     = 18,
    parameter int CNT_W         = 19,
    parameter int FEAT_ADDR_W   = 16,
    parameter int FEAT_WIDTH    = 32,
    parameter int RD_LAT        = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_clear,
    input  logic [NUM_CH*CNT_W-1:0]         cfg_expect_words,
    input  logic [NUM_CH*TOP_WIDTH-1:0]     ch_din,
    input  logic [NUM_CH-1:0]               ch_ena,
    input  logic [NUM_CH-1:0]               ch_wea,
    input  logic [NUM_CH*(CH_ADDR_W+2)-1:0] ch_addra,
    input  logic [NUM_CH-1:0]               ch_load_done,
    output logic [NUM_CH*CH_DATA_WIDTH-1:0] core_din,
    output logic [NUM_CH-1:0]               core_we,
    output logic [NUM_CH*CH_ADDR_W-1:0]     core_addr,
    output logic                            core_start,
    input  logic                            core_ready,
    output logic                            gat_ready,
    input  logic [FEAT_ADDR_W+1:0]          feat_addrb,
    input  logic                            feat_rd_en,
    output logic [FEAT_ADDR_W-1:0]          core_feat_addr,
    input  logic [FEAT_WIDTH-1:0]           core_feat_dout,
    output logic [FEAT_WIDTH-1:0]           feat_dout,
    output logic                            feat_dout_vld,
    output logic [TOP_WIDTH-1:0]            status
);

    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_START    = 2'd1,
        ST_RUN      = 2'd2,
        ST_COMPLETE = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_CH-1:0]        we_q, we_d;
    logic [NUM_CH-1:0]        done_q, done_d;
    logic [NUM_CH-1:0]        err_align_q, err_align_d;
    logic [NUM_CH-1:0]        err_count_q, err_count_d;
    logic [NUM_CH-1:0]        err_busy_q, err_busy_d;
    logic [CNT_W-1:0]         cnt_q [NUM_CH];
    logic [CNT_W-1:0]         cnt_d [NUM_CH];
    logic [CH_ADDR_W-1:0]     addr_q [NUM_CH];
    logic [CH_ADDR_W-1:0]     addr_d [NUM_CH];
    logic [CH_DATA_WIDTH-1:0] din_q [NUM_CH];
    logic [CH_DATA_WIDTH-1:0] din_d [NUM_CH];
    logic [RD_LAT-1:0]        rd_sr_q, rd_sr_d;
    logic [FEAT_WIDTH-1:0]    feat_q, feat_d;
    logic                     feat_vld_q, feat_vld_d;

    logic [CH_ADDR_W+1:0]     host_addr;
    logic [CNT_W-1:0]         exp_words;
    logic                     wr_req;
    logic                     accept;

    // Per-channel write acceptance, counting, done tracking and error flags
    always_comb begin
        we_d        = '0;
        done_d      = done_q;
        err_align_d = err_align_q;
        err_count_d = err_count_q;
        err_busy_d  = err_busy_q;
        host_addr   = '0;
        exp_words   = '0;
        wr_req      = 1'b0;
        accept      = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            addr_d[i] = addr_q[i];
            din_d[i]  = din_q[i];
            host_addr = ch_addra[i*(CH_ADDR_W+2) +: (CH_ADDR_W+2)];
            exp_words = cfg_expect_words[i*CNT_W +: CNT_W];
            wr_req    = ch_ena[i] & ch_wea[i];
            accept    = wr_req && (state_q == ST_LOAD) && (host_addr[1:0] == 2'b00) && !cfg_clear;
            if (accept) begin
                we_d[i]   = 1'b1;
                addr_d[i] = host_addr[CH_ADDR_W+1:2];
                din_d[i]  = ch_din[i*TOP_WIDTH +: CH_DATA_WIDTH];
                cnt_d[i]  = (cnt_q[i] == {CNT_W{1'b1}}) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
            end
            if (wr_req && (host_addr[1:0] != 2'b00)) err_align_d[i] = 1'b1;
            if (wr_req && (state_q != ST_LOAD))      err_busy_d[i]  = 1'b1;
            if (!done_q[i]) begin
                if (ch_load_done[i]) begin
                    if (cnt_q[i] == exp_words) done_d[i]      = 1'b1;
                    else                       err_count_d[i] = 1'b1;
                end
            end else if (accept && (cnt_d[i] > exp_words)) begin
                // Overshoot after completion: host wrote more than promised
                done_d[i]      = 1'b0;
                err_count_d[i] = 1'b1;
            end
            if (cfg_clear) begin
                cnt_d[i]       = '0;
                done_d[i]      = 1'b0;
                err_align_d[i] = 1'b0;
                err_count_d[i] = 1'b0;
                err_busy_d[i]  = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:     if (&done_q) state_d = ST_START;
            ST_START:    state_d = ST_RUN;
            ST_RUN:      if (core_ready) state_d = ST_COMPLETE;
            ST_COMPLETE: state_d = ST_COMPLETE;
            default:     state_d = ST_LOAD;
        endcase
        if (cfg_clear) state_d = ST_LOAD;
    end

    // Read strobe is delayed to line up with the core BRAM's data return
    always_comb begin
        rd_sr_d    = '0;
        rd_sr_d[0] = feat_rd_en;
        for (int k = 1; k < RD_LAT; k++) rd_sr_d[k] = rd_sr_q[k-1];
        feat_vld_d = rd_sr_q[RD_LAT-1];
        feat_d     = feat_vld_d ? core_feat_dout : feat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            we_q        <= '0;
            done_q      <= '0;
            err_align_q <= '0;
            err_count_q <= '0;
            err_busy_q  <= '0;
            rd_sr_q     <= '0;
            feat_q      <= '0;
            feat_vld_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                addr_q[i] <= '0;
                din_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            done_q      <= done_d;
            err_align_q <= err_align_d;
            err_count_q <= err_count_d;
            err_busy_q  <= err_busy_d;
            rd_sr_q     <= rd_sr_d;
            feat_q      <= feat_d;
            feat_vld_q  <= feat_vld_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                addr_q[i] <= addr_d[i];
                din_q[i]  <= din_d[i];
            end
        end
    end

    always_comb begin
        core_din  = '0;
        core_addr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            core_din[i*CH_DATA_WIDTH +: CH_DATA_WIDTH] = din_q[i];
            core_addr[i*CH_ADDR_W +: CH_ADDR_W]        = addr_q[i];
        end
        status                         = '0;
        status[1:0]                    = state_q;
        status[2 +: NUM_CH]            = done_q;
        status[2 + NUM_CH +: NUM_CH]   = err_align_q;
        status[2 + 2*NUM_CH +: NUM_CH] = err_count_q;
        status[2 + 3*NUM_CH +: NUM_CH] = err_busy_q;
    end

    assign core_we        = we_q;
    assign core_start     = (state_q == ST_START);
    assign gat_ready      = (state_q == ST_COMPLETE);
    assign core_feat_addr = feat_addrb[FEAT_ADDR_W+1:2];
    assign feat_dout      = feat_q;
    assign feat_dout_vld  = feat_vld_q;

    // Upper host data bits and byte-lane address bits are intentionally ignored
    logic unused_ok;
    assign unused_ok = ^{ch_din, feat_addrb[1:0]};

endmodule

// File: tb/tb_gat_bram_bridge.sv
// Randomized and directed bench for gat_bram_bridge against a behavioural reference model.
module tb_gat_bram_bridge;

    localparam int TOP_WIDTH     = 32;
    localparam int NUM_CH        = 3;
    localparam int CH_DATA_WIDTH = 19;
    localparam int CH_ADDR_W     = 18;
    localparam int CNT_W         = 19;
    localparam int FEAT_ADDR_W   = 16;
    localparam int FEAT_WIDTH    = 32;
    localparam int RD_LAT        = 2;
    localparam int AW            = CH_ADDR_W + 2;

    logic                            clk = 1'b0;
    logic                            rst = 1'b0;
    logic                            cfg_clear = 1'b0;
    logic [NUM_CH*CNT_W-1:0]         cfg_expect_words = '0;
    logic [NUM_CH*TOP_WIDTH-1:0]     ch_din = '0;
    logic [NUM_CH-1:0]               ch_ena = '0;
    logic [NUM_CH-1:0]               ch_wea = '0;
    logic [NUM_CH*AW-1:0]            ch_addra = '0;
    logic [NUM_CH-1:0]               ch_load_done = '0;
    logic [NUM_CH*CH_DATA_WIDTH-1:0] core_din;
    logic [NUM_CH-1:0]               core_we;
    logic [NUM_CH*CH_ADDR_W-1:0]     core_addr;
    logic                            core_start;
    logic                            core_ready = 1'b0;
    logic                            gat_ready;
    logic [FEAT_ADDR_W+1:0]          feat_addrb = '0;
    logic                            feat_rd_en = 1'b0;
    logic [FEAT_ADDR_W-1:0]          core_feat_addr;
    logic [FEAT_WIDTH-1:0]           core_feat_dout;
    logic [FEAT_WIDTH-1:0]           feat_dout;
    logic                            feat_dout_vld;
    logic [TOP_WIDTH-1:0]            status;

    gat_bram_bridge #(
        .TOP_WIDTH(TOP_WIDTH), .NUM_CH(NUM_CH), .CH_DATA_WIDTH(CH_DATA_WIDTH),
        .CH_ADDR_W(CH_ADDR_W), .CNT_W(CNT_W), .FEAT_ADDR_W(FEAT_ADDR_W),
        .FEAT_WIDTH(FEAT_WIDTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .cfg_clear(cfg_clear), .cfg_expect_words(cfg_expect_words),
        .ch_din(ch_din), .ch_ena(ch_ena), .ch_wea(ch_wea), .ch_addra(ch_addra),
        .ch_load_done(ch_load_done), .core_din(core_din), .core_we(core_we),
        .core_addr(core_addr), .core_start(core_start), .core_ready(core_ready),
        .gat_ready(gat_ready), .feat_addrb(feat_addrb), .feat_rd_en(feat_rd_en),
        .core_feat_addr(core_feat_addr), .core_feat_dout(core_feat_dout),
        .feat_dout(feat_dout), .feat_dout_vld(feat_dout_vld), .status(status)
    );

    always #5 clk = ~clk;

    // Core feature BRAM: fixed content, RD_LAT cycles from address to data
    function automatic logic [FEAT_WIDTH-1:0] feat_mem(input logic [FEAT_ADDR_W-1:0] w);
        return {w ^ 16'h5A3C, w};
    endfunction

    logic [FEAT_ADDR_W-1:0] bram_pipe [RD_LAT];
    always @(posedge clk) begin
        bram_pipe[0] <= core_feat_addr;
        for (int k = 1; k < RD_LAT; k++) bram_pipe[k] <= bram_pipe[k-1];
    end
    assign core_feat_dout = feat_mem(bram_pipe[RD_LAT-1]);

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int                       m_st;
    logic [CNT_W-1:0]         m_cnt [NUM_CH];
    logic [NUM_CH-1:0]        m_done, m_ea, m_ec, m_eb, m_we;
    logic [CH_ADDR_W-1:0]     m_addr [NUM_CH];
    logic [CH_DATA_WIDTH-1:0] m_din [NUM_CH];
    bit                       m_rd_en_q [$];
    logic [FEAT_WIDTH-1:0]    m_rd_dat_q [$];
    logic                     m_vld;
    logic [FEAT_WIDTH-1:0]    m_fd;

    task automatic model_reset();
        m_st = 0;
        m_done = '0; m_ea = '0; m_ec = '0; m_eb = '0; m_we = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = '0; m_addr[i] = '0; m_din[i] = '0;
        end
        m_rd_en_q.delete();
        m_rd_dat_q.delete();
        for (int k = 0; k < RD_LAT; k++) begin
            m_rd_en_q.push_back(1'b0);
            m_rd_dat_q.push_back('0);
        end
        m_vld = 1'b0;
        m_fd  = '0;
    endtask

    task automatic model_edge();
        int nst;
        bit all_done;
        bit en_out;
        logic [FEAT_WIDTH-1:0] dat_out;
        all_done = (m_done == {NUM_CH{1'b1}});
        for (int i = 0; i < NUM_CH; i++) begin
            logic [AW-1:0]    a;
            logic [CNT_W-1:0] ex;
            logic [CNT_W-1:0] newc;
            bit wr, al, acc;
            a    = ch_addra[i*AW +: AW];
            ex   = cfg_expect_words[i*CNT_W +: CNT_W];
            wr   = ch_ena[i] && ch_wea[i];
            al   = (a % 4) == 0;
            acc  = wr && al && (m_st == 0) && !cfg_clear;
            newc = m_cnt[i];
            if (acc && m_cnt[i] != {CNT_W{1'b1}}) newc = m_cnt[i] + 1;
            m_we[i] = acc;
            if (acc) begin
                m_addr[i] = a / 4;
                m_din[i]  = ch_din[i*TOP_WIDTH +: CH_DATA_WIDTH];
            end
            if (wr && !al)     m_ea[i] = 1'b1;
            if (wr && m_st != 0) m_eb[i] = 1'b1;
            if (!m_done[i] && ch_load_done[i]) begin
                if (m_cnt[i] == ex) m_done[i] = 1'b1;
                else                m_ec[i]   = 1'b1;
            end else if (m_done[i] && acc && newc > ex) begin
                m_done[i] = 1'b0;
                m_ec[i]   = 1'b1;
            end
            m_cnt[i] = newc;
            if (cfg_clear) begin
                m_cnt[i] = '0; m_done[i] = 1'b0;
                m_ea[i] = 1'b0; m_ec[i] = 1'b0; m_eb[i] = 1'b0;
            end
        end
        nst = m_st;
        if (m_st == 0 && all_done)      nst = 1;
        else if (m_st == 1)             nst = 2;
        else if (m_st == 2 && core_ready) nst = 3;
        if (cfg_clear) nst = 0;
        m_st = nst;
        m_rd_en_q.push_back(feat_rd_en);
        m_rd_dat_q.push_back(feat_mem(feat_addrb / 4));
        en_out  = m_rd_en_q.pop_front();
        dat_out = m_rd_dat_q.pop_front();
        m_vld = en_out;
        if (en_out) m_fd = dat_out;
    endtask

    function automatic logic [TOP_WIDTH-1:0] exp_status();
        logic [TOP_WIDTH-1:0] s;
        s = TOP_WIDTH'(m_st);
        s = s | (TOP_WIDTH'(m_done) << 2);
        s = s | (TOP_WIDTH'(m_ea) << (2 + NUM_CH));
        s = s | (TOP_WIDTH'(m_ec) << (2 + 2*NUM_CH));
        s = s | (TOP_WIDTH'(m_eb) << (2 + 3*NUM_CH));
        return s;
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < NUM_CH; i++) begin
            check_eq($sformatf("core_we%0d", i), core_we[i], m_we[i]);
            if (m_we[i]) begin
                check_eq($sformatf("core_addr%0d", i), core_addr[i*CH_ADDR_W +: CH_ADDR_W], m_addr[i]);
                check_eq($sformatf("core_din%0d", i), core_din[i*CH_DATA_WIDTH +: CH_DATA_WIDTH], m_din[i]);
            end
        end
        check_eq("core_start", core_start, m_st == 1);
        check_eq("gat_ready", gat_ready, m_st == 3);
        check_eq("status", status, exp_status());
        check_eq("feat_vld", feat_dout_vld, m_vld);
        check_eq("feat_dout", feat_dout, m_fd);
        check_eq("core_feat_addr", core_feat_addr, feat_addrb / 4);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check_outputs();
        if (core_start) n_start++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        check_outputs();
        step();
        rst = 1'b0;
    endtask

    task automatic set_write(input int ch, input logic [AW-1:0] a, input logic [31:0] d);
        ch_ena[ch] = 1'b1;
        ch_wea[ch] = 1'b1;
        ch_addra[ch*AW +: AW] = a;
        ch_din[ch*TOP_WIDTH +: TOP_WIDTH] = d;
    endtask

    task automatic idle_writes();
        ch_ena = '0;
        ch_wea = '0;
    endtask

    task automatic set_expect(input int e0, input int e1, input int e2);
        cfg_expect_words = {CNT_W'(e2), CNT_W'(e1), CNT_W'(e0)};
    endtask

    task automatic wait_start(input string tag, input int limit);
        bit seen;
        seen = 0;
        for (int n = 0; n < limit && !seen; n++) begin
            step();
            if (core_start) seen = 1;
        end
        check_eq(tag, seen, 1'b1);
    endtask

    task automatic full_load();
        int base;
        set_expect(4, 2, 3);
        for (int k = 0; k < 4; k++) begin
            set_write(0, AW'(32'h400 + k*4), $urandom);
            if (k < 2) set_write(1, AW'(32'h80 + k*4), $urandom);
            else begin ch_ena[1] = 1'b0; ch_wea[1] = 1'b0; end
            if (k < 3) set_write(2, AW'(k*4), $urandom);
            else begin ch_ena[2] = 1'b0; ch_wea[2] = 1'b0; end
            step();
        end
        idle_writes();
        ch_load_done = '1;
        base = n_start;
        wait_start("start_seen", 10);
        check_eq("status_start", status[1:0], 2'd1);
        step();
        check_eq("status_run", status[1:0], 2'd2);
        step();
        step();
        check_eq("start_pulses", n_start - base, 1);
    endtask

    initial begin
        logic [FEAT_WIDTH-1:0] rd_seen [4];
        int base;
        model_reset();
        do_reset();
        check_eq("reset_status", status, '0);

        // Full load, start, then reset mid-run and repeat
        full_load();
        do_reset();
        check_eq("rst_status", status, '0);
        check_eq("rst_start", core_start, 1'b0);
        ch_load_done = '0;
        full_load();

        // Busy write in RUN, then completion
        set_write(2, AW'(32'h10), 32'h1234);
        step();
        idle_writes();
        check_eq("err_busy2", status[2 + 3*NUM_CH + 2], 1'b1);
        core_ready = 1'b1;
        step();
        core_ready = 1'b0;
        check_eq("gat_ready_rise", gat_ready, 1'b1);
        step(); step();
        check_eq("gat_ready_hold", gat_ready, 1'b1);

        // Misaligned write, then clear
        cfg_clear = 1'b1; ch_load_done = '0;
        step();
        cfg_clear = 1'b0;
        set_write(0, AW'(32'h6), 32'hABCD);
        step();
        idle_writes();
        check_eq("misalign_we", core_we[0], 1'b0);
        check_eq("err_align0", status[2 + NUM_CH], 1'b1);
        cfg_clear = 1'b1;
        step();
        cfg_clear = 1'b0;
        check_eq("err_align_clr", status[2 + NUM_CH], 1'b0);

        // Count mismatch on ch1, then recovery
        set_expect(1, 2, 1);
        set_write(0, AW'(0), 32'h11);
        set_write(1, AW'(0), 32'h22);
        set_write(2, AW'(0), 32'h33);
        step();
        idle_writes();
        ch_load_done = '1;
        base = n_start;
        step(); step(); step();
        check_eq("err_count1", status[2 + 2*NUM_CH + 1], 1'b1);
        check_eq("no_start", n_start - base, 0);
        set_write(1, AW'(4), 32'h44);
        step();
        idle_writes();
        wait_start("start_after_fix", 6);
        cfg_clear = 1'b1; ch_load_done = '0;
        step();
        cfg_clear = 1'b0;

        // Back-to-back feature reads
        for (int k = 0; k < 4 + RD_LAT + 1; k++) begin
            feat_rd_en = (k < 4);
            feat_addrb = (k < 4) ? (FEAT_ADDR_W+2)'(k*4) : '0;
            step();
            if (k >= RD_LAT && k < RD_LAT + 4) begin
                check_eq($sformatf("rd_vld%0d", k - RD_LAT), feat_dout_vld, 1'b1);
                rd_seen[k - RD_LAT] = feat_dout;
            end
        end
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("rd_data%0d", k), rd_seen[k], feat_mem(FEAT_ADDR_W'(k)));

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                continue;
            end
            cfg_clear = ($urandom_range(0, 79) == 0);
            if (cfg_clear)
                set_expect($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            for (int i = 0; i < NUM_CH; i++) begin
                ch_ena[i] = ($urandom_range(0, 4) == 0);
                ch_wea[i] = ($urandom_range(0, 5) != 0);
                ch_addra[i*AW +: AW] = AW'({$urandom_range(0, 255), ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00});
                ch_din[i*TOP_WIDTH +: TOP_WIDTH] = $urandom;
                if ($urandom_range(0, 7) == 0) ch_load_done[i] = ~ch_load_done[i];
            end
            core_ready = ($urandom_range(0, 5) == 0);
            feat_rd_en = $urandom_range(0, 1);
            feat_addrb = (FEAT_ADDR_W+2)'($urandom);
            step();
        end
        cfg_clear = 1'b0;
        idle_writes();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
